v_mem_xfer_arbiter: RTL and testbench

- Shares the single vector DDR transfer controller between NUM_REQ vector load/store requesters (lane LSUs, prefetch).
- Arbitrates round-robin and drives the read (ctrl_r*) or write (ctrl_w*) control channel.
- Sequences one transfer at a time: start pulse, wait for done.
- Monitors stream beats and flags a size mismatch or a timeout.
- Sits between the vector load/store units and the DDR/AXI master shim.

---
 rtl/v_mem_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/v_mem_xfer_arbiter.sv | 175 +++++++++++++++++
 tb/tb_v_mem_xfer_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_mem_arb_pkg.sv
// Shared types and helpers for the vector memory transfer arbiter.
package v_mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDone
  } state_e;

  localparam int unsigned BYTES_PER_BEAT = 4;

  // Ceil division; one extra bit keeps sizes near 2^32 from overflowing.
  function automatic logic [32:0] beats_for_size(input logic [31:0] size);
    logic [32:0] sum;
    sum = {1'b0, size} + 33'(BYTES_PER_BEAT - 1);
    return sum >> $clog2(BYTES_PER_BEAT);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_gnt_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_gnt_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    int unsigned j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      j = (32'(last_gnt_i) + i) % NUM_REQ;
      if (!any_o && req_i[IdxW'(j)]) begin
        any_o              = 1'b1;
        gnt_o[IdxW'(j)]    = 1'b1;
        idx_o              = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/v_mem_xfer_arbiter.sv
// Round-robin arbiter sharing one vector DDR transfer controller between requesters,
// sequencing one transfer at a time and flagging beat-count mismatches and timeouts.
module v_mem_xfer_arbiter
  import v_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SIZE_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*SIZE_W-1:0] req_size_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      err_o,
  input  logic                      err_clr_i,
  output logic                      busy_o,
  output logic [ADDR_W-1:0]         ctrl_raddr_offset_o,
  output logic [SIZE_W-1:0]         ctrl_rxfer_size_o,
  output logic                      ctrl_rstart_o,
  input  logic                      ctrl_rdone_i,
  output logic [ADDR_W-1:0]         ctrl_waddr_offset_o,
  output logic [SIZE_W-1:0]         ctrl_wxfer_size_o,
  output logic                      ctrl_wstart_o,
  input  logic                      ctrl_wdone_i,
  input  logic                      rd_tvalid_i,
  input  logic                      rd_tready_i,
  input  logic                      wr_tvalid_i,
  input  logic                      wr_tready_i
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BeatW = SIZE_W - 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [IdxW-1:0]     last_gnt_q, last_gnt_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic                tmo_hit_q, tmo_hit_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IdxW-1:0]     arb_idx;
  logic                arb_any;
  logic [ADDR_W-1:0]   arb_addr;
  logic [SIZE_W-1:0]   arb_size;
  logic                sel_done, sel_beat, xfer_err, active;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req_i     (req_i),
    .last_gnt_i(last_gnt_q),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx),
    .any_o     (arb_any)
  );

  assign arb_addr = req_addr_i[32'(arb_idx) * ADDR_W +: ADDR_W];
  assign arb_size = req_size_i[32'(arb_idx) * SIZE_W +: SIZE_W];
  assign sel_done = we_q ? ctrl_wdone_i : ctrl_rdone_i;
  assign sel_beat = we_q ? (wr_tvalid_i && wr_tready_i) : (rd_tvalid_i && rd_tready_i);

  // The zero-size path never enters WAIT, so it cannot mismatch.
  assign xfer_err = tmo_hit_q ||
                    ((size_q != '0) && (33'(beat_q) != beats_for_size(32'(size_q))));

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      gnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      last_gnt_q <= IdxW'(NUM_REQ - 1);
      beat_q     <= '0;
      tmo_q      <= '0;
      tmo_hit_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      last_gnt_q <= last_gnt_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      tmo_hit_q  <= tmo_hit_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (arb_any) state_d = (arb_size == '0) ? StDone : StStart;
      StStart: state_d = StWait;
      StWait:  if (sel_done || (tmo_q == TmoLast)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    size_d     = size_q;
    last_gnt_d = last_gnt_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    tmo_hit_d  = tmo_hit_q;
    case (state_q)
      StIdle: begin
        if (arb_any) begin
          idx_d     = arb_idx;
          gnt_d     = arb_gnt;
          we_d      = req_we_i[arb_idx];
          addr_d    = arb_addr;
          size_d    = arb_size;
          tmo_hit_d = 1'b0;
        end
      end
      StStart: begin
        beat_d    = '0;
        tmo_d     = '0;
        tmo_hit_d = 1'b0;
      end
      StWait: begin
        if (sel_beat && (beat_q != '1)) beat_d = beat_q + BeatW'(1);
        tmo_d = tmo_q + TmoW'(1);
        if (!sel_done && (tmo_q == TmoLast)) tmo_hit_d = 1'b1;
      end
      StDone:  last_gnt_d = idx_q;
      default: ;
    endcase
  end

  // A set in the DONE cycle overrides a coincident clear.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if ((state_q == StDone) && xfer_err) err_d = 1'b1;
  end

  always_comb begin
    active              = (state_q != StIdle);
    busy_o              = active;
    err_o               = err_q;
    gnt_o               = active ? gnt_q : '0;
    done_o              = (state_q == StDone) ? gnt_q : '0;
    ctrl_raddr_offset_o = (active && !we_q) ? addr_q : '0;
    ctrl_rxfer_size_o   = (active && !we_q) ? size_q : '0;
    ctrl_waddr_offset_o = (active && we_q) ? addr_q : '0;
    ctrl_wxfer_size_o   = (active && we_q) ? size_q : '0;
    ctrl_rstart_o       = (state_q == StStart) && !we_q;
    ctrl_wstart_o       = (state_q == StStart) && we_q;
  end

endmodule

// File: tb/tb_v_mem_xfer_arbiter.sv
// Scenario bench for v_mem_xfer_arbiter with a queue of expected completions.
module tb_v_mem_xfer_arbiter;

  localparam int unsigned NR = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NR-1:0]  req, req_we;
  logic [NR*32-1:0] req_addr, req_size;
  logic [NR-1:0]  gnt, done;
  logic           err, err_clr, busy;
  logic [31:0]    raddr, rsize, waddr, wsize;
  logic           rstart, wstart, rdone, wdone;
  logic           rdv, rdr, wrv, wrr;

  int total = 0;
  int bad   = 0;
  logic [NR-1:0] exp_q[$];

  always #5 clk = ~clk;

  v_mem_xfer_arbiter #(
    .NUM_REQ(NR), .ADDR_W(32), .SIZE_W(32), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
    .gnt_o(gnt), .done_o(done), .err_o(err), .err_clr_i(err_clr), .busy_o(busy),
    .ctrl_raddr_offset_o(raddr), .ctrl_rxfer_size_o(rsize), .ctrl_rstart_o(rstart),
    .ctrl_rdone_i(rdone),
    .ctrl_waddr_offset_o(waddr), .ctrl_wxfer_size_o(wsize), .ctrl_wstart_o(wstart),
    .ctrl_wdone_i(wdone),
    .rd_tvalid_i(rdv), .rd_tready_i(rdr), .wr_tvalid_i(wrv), .wr_tready_i(wrr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] s);
    req_we[i]          = w;
    req_addr[i*32 +: 32] = a;
    req_size[i*32 +: 32] = s;
    req[i]             = 1'b1;
  endtask

  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (rstart || wstart) ok = 1'b1;
      else tick();
    end
  endtask

  // Called in START; returns in the DONE cycle (if the DUT behaves).
  task automatic serve(input logic w, input int nbeats);
    tick();
    if (w) begin wrv = 1'b1; wrr = 1'b1; end
    else begin rdv = 1'b1; rdr = 1'b1; end
    repeat (nbeats) tick();
    rdv = 1'b0; rdr = 1'b0; wrv = 1'b0; wrr = 1'b0;
    if (w) wdone = 1'b1; else rdone = 1'b1;
    tick();
    rdone = 1'b0; wdone = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    tick(); tick();
    total++;
    if ({gnt, done, err, busy, rstart, wstart} !== '0) begin
      bad++;
      $display("FAIL reset_ctl: got %b exp 0", {gnt, done, err, busy, rstart, wstart});
    end
    total++;
    if ({raddr, rsize, waddr, wsize} !== '0) begin
      bad++;
      $display("FAIL reset_bus: got %h exp 0", {raddr, rsize, waddr, wsize});
    end
    rstn = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single_read();
    logic [NR-1:0] e;
    set_req(0, 1'b0, 32'h100, 32'd16);
    exp_q.push_back(4'b0001);
    tick();
    total++;
    if ({rstart, wstart, gnt} !== {2'b10, 4'b0001}) begin
      bad++;
      $display("FAIL rd_start: got %b exp 100001", {rstart, wstart, gnt});
    end
    total++;
    if ({raddr, rsize, waddr, wsize} !== {32'h100, 32'd16, 64'd0}) begin
      bad++;
      $display("FAIL rd_bus: got %h exp 100/10/0/0", {raddr, rsize, waddr, wsize});
    end
    tick();
    total++;
    if ({rstart, raddr, rsize} !== {1'b0, 32'h100, 32'd16}) begin
      bad++;
      $display("FAIL rd_hold: got %h exp 0/100/10", {rstart, raddr, rsize});
    end
    rdv = 1'b1; rdr = 1'b1;
    repeat (4) tick();
    rdv = 1'b0; rdr = 1'b0; rdone = 1'b1;
    tick();
    rdone = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (done !== e) begin bad++; $display("FAIL rd_done: got %b exp %b", done, e); end
    req = '0;
    tick();
    total++;
    if ({err, busy, done} !== '0) begin
      bad++;
      $display("FAIL rd_after: got %b exp 0", {err, busy, done});
    end
  endtask

  task automatic test_round_robin();
    logic ok;
    logic [NR-1:0] e;
    rstn = 1'b1; tick(); rstn = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'(i * 64), 32'd4);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int k = 0; k < 5; k++) begin
      wait_start(ok);
      total++;
      if (!ok || gnt !== exp_q[0]) begin
        bad++;
        $display("FAIL rr_gnt%0d: got %b (started %b) exp %b", k, gnt, ok, exp_q[0]);
      end
      serve(1'b0, 1);
      e = exp_q.pop_front();
      total++;
      if (done !== e) begin bad++; $display("FAIL rr_done%0d: got %b exp %b", k, done, e); end
      if (k == 4) req = '0;
      tick();
    end
    total++;
    if ({err, busy} !== 2'b00) begin bad++; $display("FAIL rr_end: got %b exp 00", {err, busy}); end
  endtask

  task automatic test_write_mismatch();
    logic ok;
    logic [NR-1:0] e;
    set_req(2, 1'b1, 32'h2000, 32'd32);
    exp_q.push_back(4'b0100);
    wait_start(ok);
    total++;
    if ({ok, wstart, rstart} !== 3'b110) begin
      bad++;
      $display("FAIL wr_start: got %b exp 110", {ok, wstart, rstart});
    end
    total++;
    if ({waddr, wsize, raddr, rsize} !== {32'h2000, 32'd32, 64'd0}) begin
      bad++;
      $display("FAIL wr_bus: got %h exp 2000/20/0/0", {waddr, wsize, raddr, rsize});
    end
    serve(1'b1, 7);
    e = exp_q.pop_front();
    total++;
    if (done !== e) begin bad++; $display("FAIL wr_done: got %b exp %b", done, e); end
    req = '0;
    tick();
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL wr_err: got %b exp 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clr: got %b exp 0", err); end
  endtask

  task automatic test_timeout();
    logic ok;
    int n;
    logic [NR-1:0] e;
    set_req(1, 1'b0, 32'h40, 32'd4);
    exp_q.push_back(4'b0010);
    wait_start(ok);
    n = 0;
    while (done === '0 && n < 40) begin tick(); n++; end
    total++;
    if (!ok || n != 17) begin
      bad++;
      $display("FAIL tmo_cycles: got %0d (started %b) exp 17", n, ok);
    end
    e = exp_q.pop_front();
    total++;
    if (done !== e) begin bad++; $display("FAIL tmo_done: got %b exp %b", done, e); end
    err_clr = 1'b1;
    req = '0;
    tick();
    err_clr = 1'b0;
    total++;
    if ({err, busy} !== 2'b10) begin
      bad++;
      $display("FAIL tmo_err: got %b exp 10", {err, busy});
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_zero_and_stray();
    logic ok;
    logic [NR-1:0] e;
    set_req(3, 1'b0, 32'h300, 32'd0);
    exp_q.push_back(4'b1000);
    tick();
    e = exp_q.pop_front();
    total++;
    if ({done, rstart, wstart} !== {e, 2'b00}) begin
      bad++;
      $display("FAIL zero_done: got %b exp %b00", {done, rstart, wstart}, e);
    end
    req = '0;
    tick();
    total++;
    if ({err, busy, gnt} !== '0) begin
      bad++;
      $display("FAIL zero_after: got %b exp 0", {err, busy, gnt});
    end
    set_req(1, 1'b0, 32'h80, 32'd8);
    exp_q.push_back(4'b0010);
    wait_start(ok);
    tick();
    wdone = 1'b1; rdv = 1'b1; rdr = 1'b1;
    tick(); tick();
    total++;
    if ({ok, busy, done} !== {2'b11, 4'b0000}) begin
      bad++;
      $display("FAIL stray_wdone: got %b exp 110000", {ok, busy, done});
    end
    wdone = 1'b0; rdv = 1'b0; rdr = 1'b0; rdone = 1'b1;
    tick();
    rdone = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (done !== e) begin bad++; $display("FAIL stray_done: got %b exp %b", done, e); end
    req = '0;
    tick();
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL stray_err: got %b exp 0", err); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic [NR-1:0] e;
    set_req(2, 1'b0, 32'h500, 32'd16);
    wait_start(ok);
    tick();
    #2 rstn = 1'b1;
    #1;
    total++;
    if ({gnt, done, err, busy, rstart, wstart, raddr, rsize} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got %b exp 0", {gnt, done, busy, raddr, rsize});
    end
    tick(); tick();
    rstn = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'(i * 16), 32'd4);
    exp_q.push_back(4'b0001);
    wait_start(ok);
    total++;
    if (!ok || gnt !== exp_q[0]) begin
      bad++;
      $display("FAIL post_reset_gnt: got %b (started %b) exp %b", gnt, ok, exp_q[0]);
    end
    serve(1'b0, 1);
    e = exp_q.pop_front();
    total++;
    if (done !== e) begin bad++; $display("FAIL post_reset_done: got %b exp %b", done, e); end
    req = '0;
    tick();
    total++;
    if ({err, busy} !== 2'b00) begin
      bad++;
      $display("FAIL post_reset_end: got %b exp 00", {err, busy});
    end
  endtask

  initial begin
    rstn = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_size = '0;
    err_clr = 1'b0; rdone = 1'b0; wdone = 1'b0;
    rdv = 1'b0; rdr = 1'b0; wrv = 1'b0; wrr = 1'b0;
    #1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_mismatch();
    test_timeout();
    test_zero_and_stray();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
